// File: rtl/meat_cook_controller_if.sv
// meat_cook_controller_if: control inputs and face-up colour/status outputs of one meat piece.
interface meat_cook_controller_if;
    logic       enable;
    logic       flip;
    logic       respawn;
    logic [8:0] colour_fat;
    logic [8:0] colour_muscle;
    logic [1:0] state;
    logic       cooked;
    logic       burnt;
    modport master (output enable, flip, respawn, input colour_fat, colour_muscle, state, cooked, burnt);
    modport slave (input enable, flip, respawn, output colour_fat, colour_muscle, state, cooked, burnt);
endinterface

// File: rtl/meat_cook_controller.sv
// meat_cook_controller: two-sided grill piece; the face-down side cooks on a prescaled tick, flip swaps sides.
// Optional FLIP_COOLDOWN_EN: an accepted flip locks out further flips for COOLDOWN_TICKS ticks.
module meat_cook_controller #(
    parameter int TICK_DIV       = 25000000,
    parameter int LEVEL_RARE     = 4,
    parameter int LEVEL_DONE     = 8,
    parameter int LEVEL_BURNT    = 12,
    parameter int COOLDOWN_TICKS = 2
) (
    input logic                   clk,
    input logic                   reset,
    meat_cook_controller_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [1:0] S_IDLE = 2'd0, S_COOK = 2'd1, S_BURNT = 2'd2;
    localparam logic [3:0] L_RARE = 4'(LEVEL_RARE), L_DONE = 4'(LEVEL_DONE), L_BURNT = 4'(LEVEL_BURNT);

    logic [1:0]    r_state, w_state_nxt;
    logic [3:0]    r_down, r_up, w_down_nxt, w_up_nxt, w_down_inc;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic          r_flip_q;
    logic          w_flip_pulse, w_run, w_tick, w_flip_ok;
    logic [8:0]    r_fat, r_muscle, w_fat_nxt, w_muscle_nxt;
    logic          r_cooked, r_burnt, w_cooked_nxt, w_burnt_nxt;

    assign w_flip_pulse = bus.flip & ~r_flip_q;
    assign w_run        = r_state == S_COOK && bus.enable;
    assign w_tick       = w_run && r_pre == PW'(TICK_DIV - 1);
    assign w_down_inc   = (w_tick && r_down < L_BURNT) ? r_down + 4'd1 : r_down;

`ifdef FLIP_COOLDOWN_EN
    localparam int CW = $clog2(COOLDOWN_TICKS + 2);
    logic [CW-1:0] r_cool, w_cool_nxt;
    assign w_flip_ok  = w_run && w_flip_pulse && r_cool == '0;
    assign w_cool_nxt = bus.respawn ? '0 :
                        w_flip_ok ? CW'(COOLDOWN_TICKS) :
                        (w_tick && r_cool != '0) ? r_cool - CW'(1) : r_cool;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cool <= '0;
        else       r_cool <= w_cool_nxt;
    end
`else
    assign w_flip_ok = w_run && w_flip_pulse;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_down   <= '0;
            r_up     <= '0;
            r_pre    <= '0;
            r_flip_q <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_down   <= w_down_nxt;
            r_up     <= w_up_nxt;
            r_pre    <= w_pre_nxt;
            r_flip_q <= bus.flip;
        end
    end

    // The old up side is never burnt while cooking, so only the incremented down side can trigger the burn.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_down_nxt  = r_down;
        w_up_nxt    = r_up;
        if (bus.respawn) begin
            w_state_nxt = S_IDLE;
            w_pre_nxt   = '0;
            w_down_nxt  = '0;
            w_up_nxt    = '0;
        end else if (r_state == S_IDLE) begin
            w_state_nxt = bus.enable ? S_COOK : S_IDLE;
        end else if (w_run) begin
            w_pre_nxt   = w_tick ? '0 : r_pre + PW'(1);
            w_down_nxt  = w_flip_ok ? r_up : w_down_inc;
            w_up_nxt    = w_flip_ok ? w_down_inc : r_up;
            w_state_nxt = w_down_inc == L_BURNT ? S_BURNT : S_COOK;
        end
    end

    always_comb begin
        w_burnt_nxt  = r_state == S_BURNT;
        w_cooked_nxt = !w_burnt_nxt && r_up >= L_DONE && r_down >= L_DONE;
        w_muscle_nxt = w_burnt_nxt ? 9'o000 : r_up >= L_DONE ? 9'o420 : r_up >= L_RARE ? 9'o500 : 9'o700;
        w_fat_nxt    = w_burnt_nxt ? 9'o111 : r_up >= L_DONE ? 9'o642 : r_up >= L_RARE ? 9'o664 : 9'o766;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_muscle <= 9'o700;
            r_fat    <= 9'o766;
            r_cooked <= 1'b0;
            r_burnt  <= 1'b0;
        end else begin
            r_muscle <= w_muscle_nxt;
            r_fat    <= w_fat_nxt;
            r_cooked <= w_cooked_nxt;
            r_burnt  <= w_burnt_nxt;
        end
    end

    assign bus.colour_muscle = r_muscle;
    assign bus.colour_fat    = r_fat;
    assign bus.state         = r_state;
    assign bus.cooked        = r_cooked;
    assign bus.burnt         = r_burnt;
endmodule
